// File: rtl/lc4_mem_responder.sv
// Unified word-addressed memory for the LC4 core: post-reset clear sweep, fetch/data/loader ports.
// Optional switch/LED device region is built when LC4_MEM_MMIO_EN is defined.
module lc4_mem_responder #(
    parameter int          ADDR_W      = 16,
    parameter logic [15:0] CLEAR_VALUE = 16'h0000,
    parameter logic [15:0] MMIO_BASE   = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gwe,
    input  logic [15:0] i_imem_addr,
    output logic [15:0] o_imem_data,
    input  logic [15:0] i_dmem_addr,
    input  logic        i_dmem_we,
    input  logic [15:0] i_dmem_wdata,
    output logic [15:0] o_dmem_data,
    output logic        o_ready,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [15:0] i_ld_addr,
    input  logic [15:0] i_ld_data,
    input  logic [7:0]  i_switch_data,
    output logic [7:0]  o_led_data
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [15:0]       mem_r [DEPTH];
    logic [15:0]       imem_data_r;
    logic [15:0]       dmem_data_r;
    logic              ready_r;

    logic [ADDR_W-1:0] imem_idx_s;
    logic [ADDR_W-1:0] dmem_idx_s;
    logic [ADDR_W-1:0] ld_idx_s;
    logic [ADDR_W-1:0] wr_idx_s;
    logic [15:0]       wr_data_s;
    logic              wr_en_s;
    logic              ld_fire_s;
    logic              dmem_dev_s;
    logic [15:0]       dev_rdata_s;
    logic [15:0]       dmem_rdata_s;

    assign imem_idx_s = i_imem_addr[ADDR_W-1:0];
    assign dmem_idx_s = i_dmem_addr[ADDR_W-1:0];
    assign ld_idx_s   = i_ld_addr[ADDR_W-1:0];

    // The loader yields to the data port, so the two never write in the same cycle.
    assign o_ld_ready = ready_r & ~i_dmem_we;
    assign ld_fire_s  = i_ld_valid & o_ld_ready;

`ifdef LC4_MEM_MMIO_EN
    localparam logic [15:0] LED_ADDR = MMIO_BASE + 16'd2;

    logic [7:0] led_r;
    logic       led_we_s;

    // Device region decode; an LED write returns its new value on the same cycle.
    always_comb begin
        dmem_dev_s = (i_dmem_addr >= MMIO_BASE);
        led_we_s   = dmem_dev_s & i_dmem_we & (i_dmem_addr == LED_ADDR);
        if (i_dmem_addr == MMIO_BASE) begin
            dev_rdata_s = {8'h00, i_switch_data};
        end else if (i_dmem_addr == LED_ADDR) begin
            dev_rdata_s = led_we_s ? {8'h00, i_dmem_wdata[7:0]} : {8'h00, led_r};
        end else begin
            dev_rdata_s = 16'h0000;
        end
    end

    // LED register, written only by data-port stores once the sweep is done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_r <= 8'h00;
        end else if (gwe && (state_r == ST_RUN) && led_we_s) begin
            led_r <= i_dmem_wdata[7:0];
        end
    end

    assign o_led_data = led_r;
`else
    logic unused_switch_s;

    // Without the device region every data access targets the array.
    always_comb begin
        dmem_dev_s  = 1'b0;
        dev_rdata_s = 16'h0000;
    end

    assign unused_switch_s = ^i_switch_data;
    assign o_led_data      = 8'h00;
`endif

    // Data-port read value: device, freshly written word, or array contents.
    always_comb begin
        if (dmem_dev_s) begin
            dmem_rdata_s = dev_rdata_s;
        end else if (i_dmem_we) begin
            dmem_rdata_s = i_dmem_wdata;
        end else begin
            dmem_rdata_s = mem_r[dmem_idx_s];
        end
    end

    // Single array write port shared by the sweep, the data port and the loader.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = clr_cnt_r;
        wr_data_s = CLEAR_VALUE;
        if (state_r == ST_CLEAR) begin
            wr_en_s = 1'b1;
        end else if (i_dmem_we) begin
            wr_en_s   = ~dmem_dev_s;
            wr_idx_s  = dmem_idx_s;
            wr_data_s = i_dmem_wdata;
        end else if (ld_fire_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = ld_idx_s;
            wr_data_s = i_ld_data;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Array storage; contents are initialised by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (gwe && wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Sweep/run controller with registered read outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_CLEAR;
            clr_cnt_r   <= CNT_ZERO;
            imem_data_r <= 16'h0000;
            dmem_data_r <= 16'h0000;
            ready_r     <= 1'b0;
        end else if (gwe) begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r   <= clr_cnt_r + CNT_ONE;
                    imem_data_r <= 16'h0000;
                    dmem_data_r <= 16'h0000;
                    if (clr_cnt_r == CNT_LAST) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    imem_data_r <= mem_r[imem_idx_s];
                    dmem_data_r <= dmem_rdata_s;
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    clr_cnt_r   <= CNT_ZERO;
                    imem_data_r <= 16'h0000;
                    dmem_data_r <= 16'h0000;
                    ready_r     <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_data = imem_data_r;
    assign o_dmem_data = dmem_data_r;
    assign o_ready     = ready_r;

endmodule

// File: tb/tb_lc4_mem_responder.sv
// Randomized bench for lc4_mem_responder against a behavioural memory model, plus directed literal checks.
module tb_lc4_mem_responder;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [15:0] CV    = 16'hDEAD;
    localparam logic [15:0] MB    = 16'hFE00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gwe = 1'b0;
    logic [15:0] i_imem_addr = 16'h0000;
    logic [15:0] i_dmem_addr = 16'h0000;
    logic        i_dmem_we = 1'b0;
    logic [15:0] i_dmem_wdata = 16'h0000;
    logic        i_ld_valid = 1'b0;
    logic [15:0] i_ld_addr = 16'h0000;
    logic [15:0] i_ld_data = 16'h0000;
    logic [7:0]  i_switch_data = 8'h00;
    logic [15:0] o_imem_data, o_dmem_data;
    logic        o_ready, o_ld_ready;
    logic [7:0]  o_led_data;

    int tests = 0;
    int fails = 0;

    lc4_mem_responder #(.ADDR_W(AW), .CLEAR_VALUE(CV), .MMIO_BASE(MB)) dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .i_imem_addr(i_imem_addr), .o_imem_data(o_imem_data),
        .i_dmem_addr(i_dmem_addr), .i_dmem_we(i_dmem_we), .i_dmem_wdata(i_dmem_wdata),
        .o_dmem_data(o_dmem_data), .o_ready(o_ready),
        .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
        .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .i_switch_data(i_switch_data), .o_led_data(o_led_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: count of completed sweep edges, a plain word array, and expected outputs.
    logic [15:0] m_mem [DEPTH];
    int          m_swept = 0;
    logic [15:0] m_imem = 16'h0000;
    logic [15:0] m_dmem = 16'h0000;
    logic [7:0]  m_led = 8'h00;
    logic        m_ld_fire;
    logic        m_dev;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_swept = 0;
            m_imem  = 16'h0000;
            m_dmem  = 16'h0000;
            m_led   = 8'h00;
        end else if (gwe) begin
            if (m_swept < DEPTH) begin
                m_mem[m_swept] = CV;
                m_swept++;
                m_imem = 16'h0000;
                m_dmem = 16'h0000;
            end else begin
                m_ld_fire = i_ld_valid && !i_dmem_we;
`ifdef LC4_MEM_MMIO_EN
                m_dev = (i_dmem_addr >= MB);
`else
                m_dev = 1'b0;
`endif
                m_imem = m_mem[i_imem_addr % DEPTH];
                if (m_dev) begin
                    if (i_dmem_addr == MB) begin
                        m_dmem = {8'h00, i_switch_data};
                    end else if (i_dmem_addr == MB + 16'd2) begin
                        if (i_dmem_we) m_led = i_dmem_wdata[7:0];
                        m_dmem = {8'h00, m_led};
                    end else begin
                        m_dmem = 16'h0000;
                    end
                end else if (i_dmem_we) begin
                    m_mem[i_dmem_addr % DEPTH] = i_dmem_wdata;
                    m_dmem = i_dmem_wdata;
                end else begin
                    m_dmem = m_mem[i_dmem_addr % DEPTH];
                end
                if (m_ld_fire) m_mem[i_ld_addr % DEPTH] = i_ld_data;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        chk("imem_data", o_imem_data, m_imem);
        chk("dmem_data", o_dmem_data, m_dmem);
        chk("ready", {15'd0, o_ready}, {15'd0, (m_swept >= DEPTH)});
        chk("ld_ready", {15'd0, o_ld_ready}, {15'd0, ((m_swept >= DEPTH) && !i_dmem_we)});
`ifdef LC4_MEM_MMIO_EN
        chk("led", {8'h00, o_led_data}, {8'h00, m_led});
`else
        chk("led", {8'h00, o_led_data}, 16'h0000);
`endif
    end

    function automatic logic [15:0] rand_daddr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 16'($urandom_range(0, 15));
`ifdef LC4_MEM_MMIO_EN
        if (r < 8) return MB + 16'(2 * $urandom_range(0, 2));
`endif
        return 16'($urandom);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n;
    int cyc;

    initial begin
        gwe = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem", o_imem_data, 16'h0000);
        chk("rst_dmem", o_dmem_data, 16'h0000);
        chk("rst_ready", {15'd0, o_ready}, 16'h0000);
        chk("rst_ld_ready", {15'd0, o_ld_ready}, 16'h0000);
        rst = 1'b1;

        // Sweep with a 5-cycle gwe pause; ready must follow exactly 16 gwe edges.
        n = 0;
        cyc = 0;
        while (!o_ready && cyc < 64) begin
            @(posedge clk);
            if (gwe) n++;
            cyc++;
            #1;
            gwe = !(cyc >= 6 && cyc < 11);
        end
        chk("sweep_gwe_edges", 16'(n), 16'd16);
        chk("sweep_total_cycles", 16'(cyc), 16'd21);
        gwe = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            i_imem_addr = 16'(a);
            step();
            chk("clear_value", o_imem_data, 16'hDEAD);
        end

        // Same-index data write and fetch: write-first data, read-first fetch.
        i_imem_addr = 16'h0005; i_dmem_addr = 16'h0005; i_dmem_we = 1'b1; i_dmem_wdata = 16'h1234;
        step();
        chk("wf_dmem", o_dmem_data, 16'h1234);
        chk("rf_imem_old", o_imem_data, 16'hDEAD);
        i_dmem_we = 1'b0;
        step();
        chk("rf_imem_new", o_imem_data, 16'h1234);

        // Loader stalls behind a data write, then lands.
        i_ld_valid = 1'b1; i_ld_addr = 16'h0003; i_ld_data = 16'hBEEF;
        i_dmem_we = 1'b1; i_dmem_addr = 16'h0007; i_dmem_wdata = 16'h7777;
        #1;
        chk("ld_blocked", {15'd0, o_ld_ready}, 16'h0000);
        step();
        i_dmem_we = 1'b0; i_imem_addr = 16'h0003;
        #1;
        chk("ld_open", {15'd0, o_ld_ready}, 16'h0001);
        step();
        chk("ld_not_early", o_imem_data, 16'hDEAD);
        i_ld_valid = 1'b0;
        step();
        chk("ld_landed", o_imem_data, 16'hBEEF);

`ifdef LC4_MEM_MMIO_EN
        i_switch_data = 8'hA5; i_dmem_addr = 16'hFE00;
        step();
        chk("mmio_switch", o_dmem_data, 16'h00A5);
        i_dmem_addr = 16'hFE02; i_dmem_we = 1'b1; i_dmem_wdata = 16'h003C;
        step();
        chk("mmio_led", {8'h00, o_led_data}, 16'h003C);
        i_dmem_we = 1'b0; i_dmem_addr = 16'hFE04; i_imem_addr = 16'h0002;
        step();
        chk("mmio_other", o_dmem_data, 16'h0000);
        chk("mmio_no_array", o_imem_data, 16'hDEAD);
`else
        i_dmem_addr = 16'hFE02; i_dmem_we = 1'b1; i_dmem_wdata = 16'h003C;
        step();
        chk("alias_wf", o_dmem_data, 16'h003C);
        chk("led_tied", {8'h00, o_led_data}, 16'h0000);
        i_dmem_we = 1'b0; i_dmem_addr = 16'h0012;
        step();
        chk("alias_read", o_dmem_data, 16'h003C);
`endif

        // Randomized traffic with an asynchronous reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            gwe           = ($urandom_range(0, 9) != 0);
            i_imem_addr   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            i_dmem_addr   = rand_daddr();
            i_dmem_we     = ($urandom_range(0, 9) < 3);
            i_dmem_wdata  = 16'($urandom);
            i_ld_valid    = ($urandom_range(0, 9) < 4);
            i_ld_addr     = 16'($urandom);
            i_ld_data     = 16'($urandom);
            i_switch_data = 8'($urandom);
            if (c == 700) begin
                @(posedge clk);
                #3;
                rst = 1'b0;
                #1;
                chk("async_imem", o_imem_data, 16'h0000);
                chk("async_dmem", o_dmem_data, 16'h0000);
                chk("async_ready", {15'd0, o_ready}, 16'h0000);
                chk("async_ld_ready", {15'd0, o_ld_ready}, 16'h0000);
                chk("async_led", {8'h00, o_led_data}, 16'h0000);
                step();
                rst = 1'b1;
            end else begin
                step();
            end
        end

        gwe = 1'b0;
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lc4_mem_responder.md
Name: lc4_mem_responder

Overview:
- Memory-side responder for the LC4 pipelined core.
- Answers the core's instruction-fetch port (o_cur_pc → i_cur_insn) and data port (o_dmem_addr/o_dmem_we/o_dmem_towrite → i_cur_dmem_data).
- Holds a single unified word-addressed array. After reset it zero-fills the array with a sweep FSM, then serves requests with one-cycle registered reads.
- Provides a valid/ready loader port for program images and, optionally, memory-mapped switch/LED registers.

Parameters:
ADDR_W, 16, index bits into the array (DEPTH = 2**ADDR_W); higher address bits alias.
CLEAR_VALUE, 16'h0000, word written to every location during the clear sweep.
MMIO_BASE, 16'hFE00, first address of the device region (full 16-bit compare).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
gwe  in  1  global write enable; all state updates only on clk edges with gwe=1
i_imem_addr  in  16  fetch address
o_imem_data  out  16  fetched word, registered
i_dmem_addr  in  16  data address
i_dmem_we  in  1  data write enable
i_dmem_wdata  in  16  data write value
o_dmem_data  out  16  data read word, registered
o_ready  out  1  1 when the FSM is in RUN
i_ld_valid  in  1  loader request valid
o_ld_ready  out  1  loader can accept
i_ld_addr  in  16  loader address
i_ld_data  in  16  loader word
i_switch_data  in  8  board switches
o_led_data  out  8  board LEDs

Behaviour:
- Reset (rst=0, async): state=CLEAR, clear counter=0, o_imem_data=0, o_dmem_data=0, o_led_data=0, o_ready=0, o_ld_ready=0. Reset mid-sweep or mid-RUN restarts the sweep from 0.
- The array contents are not reset directly; they are rewritten by the sweep.
- gwe=0: state, counter, outputs, array and LED register all hold.

FSM:
- CLEAR: each gwe edge writes CLEAR_VALUE at mem[counter], then counter+1.
  - Transition to RUN on the edge that writes DEPTH-1; the sweep takes DEPTH gwe cycles.
  - The dmem write and the loader are ignored. Output registers load 0.
- RUN: terminal until reset.
  - o_ready=1.
  - o_ld_ready = !i_dmem_we (combinational).

Reads (RUN), one gwe-cycle latency:
- o_imem_data <= mem[i_imem_addr[ADDR_W-1:0]].
- o_dmem_data <= mem[i_dmem_addr[ADDR_W-1:0]].

Writes and same-cycle hazards (RUN):
- i_dmem_we=1: mem[idx] <= i_dmem_wdata. o_dmem_data takes the new value (write-first).
- The imem port reading the same index in that cycle returns the old value (read-first).
- Loader handshake fires when i_ld_valid && o_ld_ready: mem[i_ld_addr idx] <= i_ld_data.
- Loader and dmem write can never both fire in one cycle.
- A held i_ld_valid with o_ld_ready=0 is retried; nothing is dropped.
- Addresses ≥ DEPTH alias via truncation; no error signal.

Optional Feature:
Macro: LC4_MEM_MMIO_EN.
- Defined: dmem accesses with i_dmem_addr ≥ MMIO_BASE bypass the array.
  - Read of MMIO_BASE returns {8'h00, i_switch_data} sampled at that edge.
  - MMIO_BASE+2 is the LED register: write sets o_led_data <= i_dmem_wdata[7:0]; read returns {8'h00, led}.
  - Other device addresses read 16'h0000; writes to them are dropped.
  - The imem port and the loader always access the array, never the device region.
- Undefined: no device region; all addresses go to the array; o_led_data is tied to 8'h00.

Test Plan:
1. ADDR_W=4, CLEAR_VALUE=16'hDEAD, rst low then high, gwe=1 → o_ready rises after exactly 16 edges; subsequent imem reads of addresses 0..15 return 16'hDEAD.
2. In RUN, dmem write 16'h1234 @ 0x0005 with imem also at 0x0005 in the same cycle → next cycle o_dmem_data=1234, o_imem_data=DEAD; the following cycle o_imem_data=1234.
3. i_ld_valid=1, i_dmem_we=1 → o_ld_ready=0 and no load; drop i_dmem_we → loader writes 16'hBEEF @ 0x0003; imem read of 0x0003 returns BEEF.
4. gwe held 0 for 5 cycles mid-sweep → counter and outputs frozen; the sweep still completes in 16 gwe edges total.
5. Assert rst low asynchronously mid-RUN between clock edges → outputs 0 immediately, o_ready=0, sweep restarts from address 0.
6. LC4_MEM_MMIO_EN defined, switches=8'hA5: dmem read of 0xFE00 → 16'h00A5; write 16'h003C @ 0xFE02 → o_led_data=3C; read of 0xFE04 → 0000.
